// File: rtl/d_ff.sv
// d_ff
// ----
// WIDTH-bit D-type register: one clock, asynchronous active-high reset.
// q reloads from d_in on every rising clk edge while rst is low (no enable)
// and is forced to RESET_VALUE as soon as rst rises, independent of clk.
// Each bit is an independent flip-flop sharing clk and rst.
//
// Ports (positional order is significant: d_ff(q, rst, clk, d_in))
//   q     out  WIDTH  registered data, driven straight from the storage flops
//   rst   in   1      asynchronous reset, active high
//   clk   in   1      sole clock, rising-edge active
//   d_in  in   WIDTH  data sampled on the rising clk edge
//
// Parameters
//   WIDTH        data width in bits (default 1)
//   RESET_VALUE  value loaded into q while rst is high (default all zeros)
//
// q has no power-on value; in simulation it is X until the first reset or
// the first rising clk edge with a known d_in.

module d_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] q,
  input  logic             rst,
  input  logic             clk,
  input  logic [WIDTH-1:0] d_in
);

  // Reset sits in the sensitivity list so it takes effect without a clock
  // edge, and it is tested first so it wins over a coincident rising clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d_in;
    end
  end

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff
// -------
// Self-checking bench for d_ff. Two instances share clk and rst:
//   dutNarrow : default parameters (WIDTH 1, reset value 0)
//   dutWide   : WIDTH 8, RESET_VALUE 8'hA5 (non-zero, per-bit independence)
// Inputs change on falling edges; q is sampled 1 time unit after rising
// edges or, for asynchronous reset, 1 time unit after rst rises.

module tb_d_ff;

  localparam int               WW      = 8;
  localparam logic [WW-1:0]    WIDERST = 8'hA5;

  logic          clk;
  logic          rst;
  logic          dNarrow;
  logic          qNarrow;
  logic [WW-1:0] dWide;
  logic [WW-1:0] qWide;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic rstVal;
    logic dVal;
    logic expQ;
  } vector_t;

  vector_t vectors[$];

  d_ff dutNarrow (
    .q    (qNarrow),
    .rst  (rst),
    .clk  (clk),
    .d_in (dNarrow)
  );

  d_ff #(
    .WIDTH       (WW),
    .RESET_VALUE (WIDERST)
  ) dutWide (
    .q    (qWide),
    .rst  (rst),
    .clk  (clk),
    .d_in (dWide)
  );

  // Clock rises at 10, 20, 30 ... and falls at 15, 25, 35 ...
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  // Hard stop in case anything ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [WW-1:0] actual,
                             input logic [WW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Drive all inputs on the next falling edge.
  task automatic applyStimulus(input logic r, input logic d, input logic [WW-1:0] dw);
    @(negedge clk);
    rst     = r;
    dNarrow = d;
    dWide   = dw;
  endtask

  task automatic afterRise();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          expN;
    logic [WW-1:0] expW;
    logic          r;
    logic          d;
    logic [WW-1:0] dw;
    logic [WW-1:0] junk;

    rst     = 1'b0;
    dNarrow = 1'b0;
    dWide   = '0;

    // Reset pulse for one full cycle from a falling edge, d_in low.
    applyStimulus(1'b1, 1'b0, 8'h3C);
    #1;
    checkOutput("rst_async_narrow", {7'd0, qNarrow}, 8'h00);
    checkOutput("rst_async_wide", qWide, WIDERST);
    afterRise();
    checkOutput("rst_hold_narrow", {7'd0, qNarrow}, 8'h00);
    checkOutput("rst_hold_wide", qWide, WIDERST);

    // Table of per-cycle vectors: set at falling edge, check after rising edge.
    vectors = '{
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1}
    };
    foreach (vectors[i]) begin
      applyStimulus(vectors[i].rstVal, vectors[i].dVal, 8'h00);
      afterRise();
      checkOutput($sformatf("table_%0d", i), {7'd0, qNarrow}, {7'd0, vectors[i].expQ});
    end

    // q is 1 here: reset mid-operation must clear q before any rising edge.
    applyStimulus(1'b1, 1'b1, 8'hFF);
    #1;
    checkOutput("midop_rst_immediate", {7'd0, qNarrow}, 8'h00);
    checkOutput("midop_rst_wide", qWide, WIDERST);
    #3;
    checkOutput("midop_rst_before_edge", {7'd0, qNarrow}, 8'h00);
    afterRise();
    checkOutput("rst_ignores_clk", {7'd0, qNarrow}, 8'h00);
    checkOutput("rst_ignores_clk_wide", qWide, WIDERST);
    applyStimulus(1'b0, 1'b1, 8'h5A);
    afterRise();
    checkOutput("first_edge_after_release", {7'd0, qNarrow}, 8'h01);
    checkOutput("first_edge_after_release_w", qWide, 8'h5A);

    // d_in changes between edges must not reach q.
    applyStimulus(1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("hold_after_fall", {7'd0, qNarrow}, 8'h01);
    checkOutput("hold_after_fall_w", qWide, 8'h5A);
    afterRise();
    checkOutput("load_zero", {7'd0, qNarrow}, 8'h00);

    // Glitch within the low phase: only the value at the rising edge counts.
    @(negedge clk);
    #1;
    dNarrow = 1'b1;
    dWide   = 8'hFF;
    #2;
    dNarrow = 1'b0;
    dWide   = 8'h00;
    #1;
    checkOutput("glitch_no_comb_path", {7'd0, qNarrow}, 8'h00);
    afterRise();
    checkOutput("glitch_not_captured", {7'd0, qNarrow}, 8'h00);
    checkOutput("glitch_not_captured_w", qWide, 8'h00);

    // Reset coincident with a rising edge: reset wins.
    applyStimulus(1'b0, 1'b1, 8'h0F);
    afterRise();
    checkOutput("pre_coincident_load", {7'd0, qNarrow}, 8'h01);
    @(posedge clk);
    rst = 1'b1;
    #1;
    checkOutput("coincident_rst_wins", {7'd0, qNarrow}, 8'h00);
    checkOutput("coincident_rst_wins_w", qWide, WIDERST);
    applyStimulus(1'b0, 1'b1, 8'hC3);
    afterRise();
    checkOutput("after_coincident", {7'd0, qNarrow}, 8'h01);
    checkOutput("after_coincident_w", qWide, 8'hC3);

    // Randomised run against a behavioural model: q after an edge is the
    // d_in seen at that edge, or the reset value whenever rst is high.
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(0, 9) == 0);
      d  = 1'($urandom);
      dw = 8'($urandom);
      applyStimulus(r, d, dw);
      if (r) begin
        #1;
        checkOutput("rand_async_rst", {7'd0, qNarrow}, 8'h00);
        checkOutput("rand_async_rst_w", qWide, WIDERST);
      end else if ($urandom_range(0, 3) == 0) begin
        #1;
        junk  = 8'($urandom);
        dWide = junk;
        #2;
        dWide = dw;
      end
      expN = r ? 1'b0 : d;
      expW = r ? WIDERST : dw;
      afterRise();
      checkOutput("rand_narrow", {7'd0, qNarrow}, {7'd0, expN});
      checkOutput("rand_wide", qWide, expW);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/d_ff.md
D_FF -- requirements
Module: d_ff

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits of d_in and q.
REQ-002 Parameter RESET_VALUE, default all-zeros (WIDTH bits), value loaded into q on reset.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port d_in  input  WIDTH  data input sampled on rising clk.
REQ-006 Port q  output  WIDTH  registered data output, driven directly from the storage register.
REQ-007 Positional port order SHALL be (q, rst, clk, d_in), so that positional instantiation d_ff(q, rst, clk, d_in) connects correctly.
REQ-008 The block SHALL have one clock and an asynchronous, active-high reset named clk and rst respectively; polarity and synchronicity are fixed.

Function
REQ-009 On a rising edge of clk with rst low, q SHALL take the value of d_in present just before the edge; latency is one clock.
REQ-010 Between rising clk edges q SHALL hold its value regardless of d_in changes; there is no combinational path from d_in to q.
REQ-011 Falling clk edges SHALL have no effect on q.
REQ-012 d_in changes coincident with the falling edge SHALL be captured on the next rising edge.
REQ-013 No enable: every rising clk edge with rst low SHALL reload q.
REQ-014 For WIDTH > 1, every bit SHALL behave as an independent flip-flop sharing clk and rst.
REQ-015 q SHALL be undefined (X in simulation) until either reset or the first rising clk edge with a known d_in; no power-on value is guaranteed.

Reset
REQ-016 When rst rises, q SHALL become RESET_VALUE immediately, without waiting for a clk edge.
REQ-017 While rst is high, q SHALL stay at RESET_VALUE and rising clk edges SHALL be ignored.
REQ-018 If rst and a rising clk edge coincide, reset SHALL win and q = RESET_VALUE.
REQ-019 After rst falls, the first rising clk edge with rst low SHALL load d_in (no extra dead cycle).
REQ-020 Reset asserted mid-operation (q = 1) SHALL force q to RESET_VALUE asynchronously; prior data is lost.
REQ-021 An X or unknown rst SHALL not be relied upon; benches SHALL drive rst to a known level before checking q.

Verification
REQ-022 Clock of period 10 (rising at 10, 20, 30 ...); rst pulsed high for one full cycle from a falling edge -> q = 0 from assertion onward, while d_in = 0.
REQ-023 After reset release, d_in = 1 at a falling edge -> q = 1 after the next rising edge; q stays 1 for 20 time units of unchanged d_in.
REQ-024 d_in = 0 at one falling edge, then d_in = 1 at the next -> q = 0 after the first following rising edge, q = 1 after the second.
REQ-025 With q = 1, rst raised at a falling edge -> q = 0 immediately (before the next rising edge); d_in = 1 held during reset -> q remains 0 until rst is low at a rising edge.
REQ-026 rst released, d_in = 1 -> q = 1 at the first rising edge after release.
REQ-027 d_in toggled between rising edges (glitch 1 then back to 0 within the low phase) -> q unaffected, shows only the value at the rising edge.
